// File: rtl/branch_hazard_scoreboard.sv
// Branch-operand hazard unit for ID-stage branch resolution: per-source forwarding
// selects, per-register latency scoreboard, stall accounting and stall watchdog.

module bhs_src_lane #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_STAGES = 2,
  parameter int SEL_W      = 2,
  parameter int NREG       = 32
) (
  input  logic                                  branch_valid,
  input  logic [REG_ADDR_W-1:0]                 src,
  input  logic [FWD_STAGES-1:0]                 stage_wr_en,
  input  logic [FWD_STAGES-1:0][REG_ADDR_W-1:0] stage_rd,
  input  logic [NREG-1:0]                       busy,
  output logic [SEL_W-1:0]                      sel,
  output logic                                  hazard
);
  logic src_live;
  assign src_live = branch_valid && (src != '0);

  always_comb begin
    sel = '0;
    // Walk oldest to youngest so the youngest matching producer is the last writer.
    for (int k = FWD_STAGES; k >= 1; k--)
      if (stage_wr_en[k-1] && (stage_rd[k-1] == src))
        sel = SEL_W'(k);
    if (!src_live)
      sel = '0;
  end

  assign hazard = src_live && busy[src];
endmodule

module branch_hazard_scoreboard #(
  parameter int NUM_SRC    = 2,
  parameter int REG_ADDR_W = 5,
  parameter int FWD_STAGES = 2,
  parameter int ALU_LAT    = 1,
  parameter int LOAD_LAT   = 2,
  parameter int MAX_STALL  = 3,
  localparam int SEL_W     = $clog2(FWD_STAGES + 1),
  localparam int MAX_LAT   = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT,
  localparam int CNT_W     = $clog2(MAX_LAT + 1),
  localparam int RUN_W     = CNT_W + 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             branch_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]    id_src,
  input  logic                             id_issue,
  input  logic                             id_wr_en,
  input  logic                             id_is_load,
  input  logic [REG_ADDR_W-1:0]            id_rd,
  input  logic [FWD_STAGES-1:0]            stage_wr_en,
  input  logic [FWD_STAGES*REG_ADDR_W-1:0] stage_rd,
  output logic [NUM_SRC*SEL_W-1:0]         fwd_sel,
  output logic                             stall,
  output logic [RUN_W-1:0]                 stall_run,
  output logic [15:0]                      stall_total,
  output logic                             stall_err
);
  localparam int NREG = 2 ** REG_ADDR_W;

  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]    src_a;
  logic [FWD_STAGES-1:0][REG_ADDR_W-1:0] srd_a;
  logic [NUM_SRC-1:0][SEL_W-1:0]         sel_a;
  logic [NUM_SRC-1:0]                    hazard;
  logic [NREG-1:0]                       busy;

  logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0]           run_q, run_d;
  logic [15:0]                total_q, total_d;
  logic                       err_q, err_d;
  logic                       issue;

  assign src_a   = id_src;
  assign srd_a   = stage_rd;
  assign fwd_sel = sel_a;

  always_comb begin
    for (int r = 0; r < NREG; r++)
      busy[r] = (cnt_q[r] != '0);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_lane
      bhs_src_lane #(
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_STAGES (FWD_STAGES),
        .SEL_W      (SEL_W),
        .NREG       (NREG)
      ) u_lane (
        .branch_valid (branch_valid),
        .src          (src_a[gi]),
        .stage_wr_en  (stage_wr_en),
        .stage_rd     (srd_a),
        .busy         (busy),
        .sel          (sel_a[gi]),
        .hazard       (hazard[gi])
      );
    end
  endgenerate

  assign stall = |hazard;
  assign issue = id_issue && !stall;

  // Issue load takes priority over the per-cycle countdown on the same register.
  always_comb begin
    cnt_d = '0;
    for (int r = 1; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : '0;
      if (issue && id_wr_en && (id_rd == REG_ADDR_W'(r)))
        cnt_d[r] = id_is_load ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);
    end
  end

  always_comb begin
    run_d   = '0;
    total_d = total_q;
    err_d   = err_q;
    if (stall) begin
      run_d = (run_q != '1) ? run_q + RUN_W'(1) : run_q;
      if (total_q != 16'hFFFF)
        total_d = total_q + 16'd1;
      if (run_q == RUN_W'(MAX_STALL))
        err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      run_q   <= '0;
      total_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      total_q <= total_d;
      err_q   <= err_d;
    end
  end

  assign stall_run   = run_q;
  assign stall_total = total_q;
  assign stall_err   = err_q;
endmodule

// File: tb/tb_branch_hazard_scoreboard.sv
// Directed bench: default-parameter unit plus a long-load-latency unit for the watchdog.

module tb_branch_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main unit, default parameters
  logic       bv, iss, wr, ld;
  logic [9:0] src;
  logic [4:0] rd;
  logic [1:0] swe;
  logic [9:0] srd;
  logic [3:0] sel;
  logic       stl;
  logic [3:0] run;
  logic [15:0] tot;
  logic       err;

  // watchdog unit, LOAD_LAT = 5, MAX_STALL = 3
  logic       w_bv, w_iss, w_wr, w_ld;
  logic [9:0] w_src;
  logic [4:0] w_rd;
  logic [3:0] w_sel;
  logic       w_stl;
  logic [4:0] w_run;
  logic [15:0] w_tot;
  logic       w_err;

  int n_chk = 0;
  int n_pass = 0;

  branch_hazard_scoreboard u_dut (
    .clk(clk), .rst_n(rst_n), .branch_valid(bv), .id_src(src), .id_issue(iss),
    .id_wr_en(wr), .id_is_load(ld), .id_rd(rd), .stage_wr_en(swe), .stage_rd(srd),
    .fwd_sel(sel), .stall(stl), .stall_run(run), .stall_total(tot), .stall_err(err)
  );

  branch_hazard_scoreboard #(.LOAD_LAT(5), .MAX_STALL(3)) u_wd (
    .clk(clk), .rst_n(rst_n), .branch_valid(w_bv), .id_src(w_src), .id_issue(w_iss),
    .id_wr_en(w_wr), .id_is_load(w_ld), .id_rd(w_rd), .stage_wr_en(2'b00), .stage_rd(10'd0),
    .fwd_sel(w_sel), .stall(w_stl), .stall_run(w_run), .stall_total(w_tot), .stall_err(w_err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bv = 0; iss = 0; wr = 0; ld = 0; rd = 0; src = 0; swe = 0; srd = 0;
    w_bv = 0; w_iss = 0; w_wr = 0; w_ld = 0; w_rd = 0; w_src = 0;
  endtask

  initial begin
    // 1: reset with random non-branch inputs
    idle();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      iss = 1'($urandom); wr = 1'($urandom); ld = 1'($urandom); rd = 5'($urandom);
      src = 10'($urandom); swe = 2'($urandom); srd = 10'($urandom);
    end
    #1;
    chk("rst_stall", stl, 0);
    chk("rst_sel", sel, 0);
    chk("rst_total", tot, 0);
    chk("rst_err", err, 0);
    idle();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) step();
    chk("idle_stall", stl, 0);
    chk("idle_run", run, 0);
    chk("idle_total", tot, 0);
    chk("idle_err", err, 0);

    // 2: ALU producer -> one stall cycle, then forward from stage 1
    iss = 1; wr = 1; rd = 5'd3;
    step();
    idle(); bv = 1; src = {5'd4, 5'd3};
    #1 chk("alu_stall", stl, 1);
    step();
    swe = 2'b01; srd = {5'd0, 5'd3};
    #1;
    chk("alu_nostall", stl, 0);
    chk("alu_sel", sel, 4'b0001);
    chk("alu_total", tot, 1);

    // 3: load producer -> two stall cycles
    step();
    idle(); iss = 1; wr = 1; ld = 1; rd = 5'd5;
    step();
    idle(); bv = 1; src = {5'd0, 5'd5};
    #1;
    chk("ld_stall1", stl, 1);
    chk("ld_run0", run, 0);
    step();
    chk("ld_stall2", stl, 1);
    chk("ld_run1", run, 1);
    step();
    swe = 2'b01; srd = {5'd0, 5'd5};
    #1;
    chk("ld_nostall", stl, 0);
    chk("ld_run2", run, 2);
    chk("ld_total", tot, 3);
    chk("ld_sel_s1", sel, 4'b0001);
    swe = 2'b10; srd = {5'd5, 5'd0};
    #1 chk("ld_sel_s2", sel, 4'b0010);

    // 4: both sources same register, youngest wins; r0 never forwards or stalls
    src = {5'd7, 5'd7}; swe = 2'b11; srd = {5'd7, 5'd7};
    #1 chk("dual_sel", sel, 4'b0101);
    src = {5'd7, 5'd3}; swe = 2'b11; srd = {5'd7, 5'd3};
    #1 chk("split_sel", sel, 4'b1001);
    src = 10'd0; swe = 2'b01; srd = 10'd0;
    #1;
    chk("r0_sel", sel, 0);
    chk("r0_stall", stl, 0);
    bv = 0; src = {5'd7, 5'd7}; swe = 2'b11; srd = {5'd7, 5'd7};
    #1 chk("nobr_sel", sel, 0);
    step();
    chk("run_clear", run, 0);

    // 5: watchdog on a 5-cycle load stall
    idle(); w_iss = 1; w_wr = 1; w_ld = 1; w_rd = 5'd9;
    step();
    idle(); w_bv = 1; w_src = {5'd0, 5'd9};
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("wd_stall%0d", c), w_stl, 1);
      chk($sformatf("wd_err%0d", c), w_err, (c >= 5) ? 1 : 0);
      step();
    end
    chk("wd_end_stall", w_stl, 0);
    chk("wd_total", w_tot, 5);
    chk("wd_err_hold", w_err, 1);
    step();
    chk("wd_err_sticky", w_err, 1);
    chk("wd_run_clr", w_run, 0);

    // 6: asynchronous reset mid-stall
    idle(); iss = 1; wr = 1; ld = 1; rd = 5'd5;
    step();
    idle(); bv = 1; src = {5'd0, 5'd5};
    #1 chk("arst_pre", stl, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_stall", stl, 0);
    chk("arst_total", tot, 0);
    chk("arst_err", err, 0);
    chk("arst_wd_err", w_err, 0);
    rst_n = 1'b1;
    step();
    chk("arst_after", stl, 0);
    chk("arst_total2", tot, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
